// File: rtl/ucode_pkg.sv
// Shared definitions for the LC3 microprogram sequencer: condition-select
// encodings, default reset/trap addresses and the sequencing-field layout.
package ucode_pkg;

    typedef enum logic [2:0] {
        COND_NONE = 3'd0,
        COND_R    = 3'd1,
        COND_BEN  = 3'd2,
        COND_ADDR = 3'd3,
        COND_PSR  = 3'd4,
        COND_INT  = 3'd5
    } cond_e;

    localparam int UCODE_ADDR_W     = 6;
    localparam int UCODE_RESET_ADDR = 18;
    localparam int UCODE_TRAP_ADDR  = 63;

    typedef struct packed {
        logic [UCODE_ADDR_W-1:0] j;
        cond_e                   cond;
        logic                    ird;
        logic                    call;
        logic                    ret;
        logic [UCODE_ADDR_W-1:0] tgt;
    } useq_fields_t;

    // One-hot OR mask applied to j; codes 6 and 7 are reserved and act as "no change".
    function automatic logic [7:0] cond_mask(
        input logic [2:0] cond,
        input logic       r,
        input logic       ben,
        input logic       ir_11,
        input logic       psr_15,
        input logic       int_req
    );
        logic [7:0] m;
        m = 8'd0;
        case (cond)
            COND_R:    m[1] = r;
            COND_BEN:  m[2] = ben;
            COND_ADDR: m[0] = ir_11;
            COND_PSR:  m[3] = psr_15;
            COND_INT:  m[4] = int_req;
            default:   m    = 8'd0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ucode_ret_stack.sv
// LIFO of micro-subroutine return addresses; push into a full stack and
// pop from an empty one are ignored (the sequencer flags those cases).
module ucode_ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   sp
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [SP_W-1:0]  r_sp;
    logic [IDX_W-1:0] w_top_idx;
    logic [IDX_W-1:0] w_wr_idx;

    assign w_top_idx = IDX_W'(r_sp - SP_W'(1));
    assign w_wr_idx  = IDX_W'(r_sp);
    assign full      = (r_sp == SP_W'(DEPTH));
    assign empty     = (r_sp == {SP_W{1'b0}});
    assign dout      = r_mem[w_top_idx];
    assign sp        = r_sp;

    // Occupancy pointer; reset discards the stack contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp <= {SP_W{1'b0}};
        end else if (push && !full) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - SP_W'(1);
        end
    end

    // Entry storage, no reset needed since entries are only read below sp.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[w_wr_idx] <= din;
        end
    end

endmodule

// File: rtl/ucode_sequencer.sv
// LC3 microprogram sequencer: next-address select, call/return stack and
// sticky error flags. Define UCODE_SEQ_WDOG_EN to add the memory-wait watchdog.
module ucode_sequencer
    import ucode_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int OP_W        = 4,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = UCODE_RESET_ADDR,
    parameter int TRAP_ADDR   = UCODE_TRAP_ADDR,
    parameter int WDOG_LIMIT  = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [ADDR_W-1:0]              j,
    input  logic [2:0]                     cond,
    input  logic                           ird,
    input  logic                           call,
    input  logic                           ret,
    input  logic [ADDR_W-1:0]              tgt,
    input  logic [OP_W-1:0]                ir_op,
    input  logic                           ir_11,
    input  logic                           r,
    input  logic                           ben,
    input  logic                           psr_15,
    input  logic                           int_req,
    output logic [ADDR_W-1:0]              upc,
    output logic [ADDR_W-1:0]              upc_next,
    output logic [$clog2(STACK_DEPTH):0]   sp,
`ifdef UCODE_SEQ_WDOG_EN
    output logic                           wdog_trip,
`endif
    output logic                           err_ovf,
    output logic                           err_unf
);
    logic [ADDR_W-1:0] r_upc;
    logic              r_err_ovf;
    logic              r_err_unf;
    logic [ADDR_W-1:0] w_jm;
    logic [ADDR_W-1:0] w_sel;
    logic [ADDR_W-1:0] w_top;
    logic              w_push;
    logic              w_pop;
    logic              w_set_ovf;
    logic              w_set_unf;
    logic              w_full;
    logic              w_empty;
    logic              w_fire;
    logic              w_step;

    assign w_jm = j | ADDR_W'(cond_mask(cond, r, ben, ir_11, psr_15, int_req));

    // Next-address priority: dispatch, return, call, then the condition-modified jump.
    always_comb begin
        w_sel     = w_jm;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        if (ird) begin
            w_sel = ADDR_W'(ir_op);
        end else if (ret) begin
            if (!w_empty) begin
                w_sel = w_top;
                w_pop = 1'b1;
            end else begin
                w_sel     = ADDR_W'(RESET_ADDR);
                w_set_unf = 1'b1;
            end
        end else if (call) begin
            w_sel = tgt;
            if (!w_full) begin
                w_push = 1'b1;
            end else begin
                w_set_ovf = 1'b1;
            end
        end else begin
            w_sel = w_jm;
        end
    end

`ifdef UCODE_SEQ_WDOG_EN
    localparam int WD_RAW = $clog2(WDOG_LIMIT + 1);
    localparam int WD_W   = (WD_RAW < 8) ? 8 : ((WD_RAW > 16) ? 16 : WD_RAW);

    logic [WD_W-1:0] r_wdog;
    logic            r_trip;
    logic            w_wait;

    assign w_fire = (r_wdog == WD_W'(WDOG_LIMIT));
    assign w_wait = (cond == COND_R) && !r && (w_sel == r_upc);

    // Counts consecutive self-looping memory waits; trips once at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= {WD_W{1'b0}};
            r_trip <= 1'b0;
        end else if (en) begin
            if (w_fire) begin
                r_wdog <= {WD_W{1'b0}};
                r_trip <= 1'b1;
            end else if (w_wait) begin
                r_wdog <= r_wdog + WD_W'(1);
            end else begin
                r_wdog <= {WD_W{1'b0}};
            end
        end
    end

    assign wdog_trip = r_trip;
`else
    assign w_fire = 1'b0;
`endif

    assign upc_next = w_fire ? ADDR_W'(TRAP_ADDR) : w_sel;
    // A watchdog trap overrides the cycle's call/return, so the stack is left alone.
    assign w_step   = en && !w_fire;

    ucode_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push && w_step),
        .pop   (w_pop && w_step),
        .din   (w_jm),
        .dout  (w_top),
        .full  (w_full),
        .empty (w_empty),
        .sp    (sp)
    );

    // Micro-PC and sticky error flags; only reset clears the flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upc     <= ADDR_W'(RESET_ADDR);
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else if (en) begin
            r_upc     <= upc_next;
            r_err_ovf <= r_err_ovf | (w_set_ovf && !w_fire);
            r_err_unf <= r_err_unf | (w_set_unf && !w_fire);
        end
    end

    assign upc     = r_upc;
    assign err_ovf = r_err_ovf;
    assign err_unf = r_err_unf;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer (default build, no watchdog):
// directed scenarios with literal expectations plus randomized traffic.
module tb_ucode_sequencer;
    logic       clk;
    logic       rst;
    logic       en;
    logic [5:0] j;
    logic [2:0] cond;
    logic       ird;
    logic       call;
    logic       ret;
    logic [5:0] tgt;
    logic [3:0] ir_op;
    logic       ir_11;
    logic       r;
    logic       ben;
    logic       psr_15;
    logic       int_req;
    logic [5:0] upc;
    logic [5:0] upc_next;
    logic [2:0] sp;
    logic       err_ovf;
    logic       err_unf;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    // Reference model state
    int m_upc;
    int m_stk[$];
    bit m_ovf;
    bit m_unf;

    ucode_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .j        (j),
        .cond     (cond),
        .ird      (ird),
        .call     (call),
        .ret      (ret),
        .tgt      (tgt),
        .ir_op    (ir_op),
        .ir_11    (ir_11),
        .r        (r),
        .ben      (ben),
        .psr_15   (psr_15),
        .int_req  (int_req),
        .upc      (upc),
        .upc_next (upc_next),
        .sp       (sp),
        .err_ovf  (err_ovf),
        .err_unf  (err_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int m_jm();
        int b;
        b = int'(j);
        case (int'(cond))
            1: if (r)       b = b | 2;
            2: if (ben)     b = b | 4;
            3: if (ir_11)   b = b | 1;
            4: if (psr_15)  b = b | 8;
            5: if (int_req) b = b | 16;
            default: ;
        endcase
        return b % 64;
    endfunction

    function automatic int m_pred();
        if (ird) return int'(ir_op);
        if (ret) return (m_stk.size() > 0) ? m_stk[$] : 18;
        if (call) return int'(tgt);
        return m_jm();
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_upc = 18;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (en) begin
            int nxt;
            nxt = m_pred();
            if (!ird) begin
                if (ret) begin
                    if (m_stk.size() > 0) void'(m_stk.pop_back());
                    else m_unf = 1'b1;
                end else if (call) begin
                    if (m_stk.size() < 4) m_stk.push_back(m_jm());
                    else m_ovf = 1'b1;
                end
            end
            m_upc = nxt;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("upc", int'(upc), m_upc);
            chk("upc_next", int'(upc_next), m_pred());
            chk("sp", int'(sp), m_stk.size());
            chk("err_ovf", int'(err_ovf), int'(m_ovf));
            chk("err_unf", int'(err_unf), int'(m_unf));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b1; j = 6'd0; cond = 3'd0; ird = 1'b0; call = 1'b0; ret = 1'b0;
        tgt = 6'd0; ir_op = 4'd0; ir_11 = 1'b0; r = 1'b0; ben = 1'b0;
        psr_15 = 1'b0; int_req = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #2 rst = 1'b1;
        #10;
        chk("rst_upc", int'(upc), 18);
        chk("rst_sp", int'(sp), 0);
        chk("rst_flags", int'({err_ovf, err_unf}), 0);
        chk_on = 1'b1;

        rst = 1'b0; j = 6'd33; cond = 3'd0;
        step();
        chk("release_upc", int'(upc), 33);

        j = 6'd25;
        step();
        cond = 3'd1; r = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wait_hold", int'(upc), 25);
        end
        r = 1'b1;
        step();
        chk("wait_exit", int'(upc), 27);

        r = 1'b0; cond = 3'd0;
        ird = 1'b1; ir_op = 4'b0100; call = 1'b1; tgt = 6'd40;
        step();
        chk("dispatch_upc", int'(upc), 4);
        chk("dispatch_sp", int'(sp), 0);

        ird = 1'b0;
        for (int i = 0; i < 4; i++) begin
            j = 6'(10 + i);
            step();
            chk("call_upc", int'(upc), 40);
            chk("call_sp", int'(sp), i + 1);
        end
        j = 6'd14;
        step();
        chk("ovf_upc", int'(upc), 40);
        chk("ovf_sp", int'(sp), 4);
        chk("ovf_flag", int'(err_ovf), 1);
        call = 1'b0; ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ret_upc", int'(upc), 13 - i);
            chk("ret_sp", int'(sp), 3 - i);
        end
        step();
        chk("unf_upc", int'(upc), 18);
        chk("unf_flag", int'(err_unf), 1);

        ret = 1'b0; call = 1'b1; j = 6'd5; tgt = 6'd40;
        step();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            j = 6'($urandom_range(0, 63)); tgt = 6'($urandom_range(0, 63));
            cond = 3'($urandom_range(0, 7)); ird = 1'($urandom_range(0, 1));
            call = 1'($urandom_range(0, 1)); ret = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            step();
            chk("stall_upc", int'(upc), 40);
            chk("stall_sp", int'(sp), 1);
            chk("stall_flags", int'({err_ovf, err_unf}), 3);
        end

        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midsub_rst_sp", int'(sp), 0);
        chk("midsub_rst_upc", int'(upc), 18);
        chk("midsub_rst_flags", int'({err_ovf, err_unf}), 0);

        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            en      = ($urandom_range(0, 7) != 0);
            ird     = ($urandom_range(0, 7) == 0);
            ret     = ($urandom_range(0, 4) == 0);
            call    = ($urandom_range(0, 3) == 0);
            j       = 6'($urandom_range(0, 63));
            tgt     = 6'($urandom_range(0, 63));
            cond    = 3'($urandom_range(0, 7));
            ir_op   = 4'($urandom_range(0, 15));
            ir_11   = 1'($urandom_range(0, 1));
            r       = 1'($urandom_range(0, 1));
            ben     = 1'($urandom_range(0, 1));
            psr_15  = 1'($urandom_range(0, 1));
            int_req = 1'($urandom_range(0, 1));
            step();
        end

        rst = 1'b0;
        idle_inputs();
        step();
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ucode_sequencer.md
Name: ucode_sequencer

Overview:
- Parametrised microprogram sequencer for the LC3 control path; next generation of the current microsequencer/control-store pairing.
- Computes the next micro-address from the current microinstruction's sequencing fields and the datapath condition inputs, then registers it.
- Adds what the current block lacks: reset-to-fetch, stall enable, a micro-subroutine call/return stack with error flags, and configurable widths.
- Sits between the control store (addressed by upc_next/upc) and the datapath flags.

Parameters:
ADDR_W, 6, micro-address width
OP_W, 4, opcode width used for IRD dispatch
STACK_DEPTH, 4, return-stack entries (power of 2, >=2)
RESET_ADDR, 18, micro-address loaded on reset and on underflow recovery
TRAP_ADDR, 63, watchdog trap target (used only with the optional feature)
WDOG_LIMIT, 255, maximum consecutive memory-wait cycles (used only with the optional feature)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  advance enable; 0 holds all state
j  in  ADDR_W  base next address from the microinstruction
cond  in  3  branch-condition select
ird  in  1  opcode dispatch
call  in  1  micro-subroutine call
ret  in  1  micro-subroutine return
tgt  in  ADDR_W  call target
ir_op  in  OP_W  IR opcode field
ir_11  in  1  IR[11] addressing-mode bit
r  in  1  memory ready
ben  in  1  branch-enable flag
psr_15  in  1  privilege bit
int_req  in  1  interrupt request
upc  out  ADDR_W  registered current micro-address
upc_next  out  ADDR_W  combinational next address, for a synchronous control store
sp  out  $clog2(STACK_DEPTH)+1  return-stack occupancy
err_ovf  out  1  sticky flag: call issued while stack full
err_unf  out  1  sticky flag: ret issued while stack empty

Behaviour:
- Reset (async, rst=1): upc=RESET_ADDR, sp=0, err_ovf=0, err_unf=0, stack contents don't-care.
- Condition-modified address jm = j with one bit ORed, selected by cond:
  - 0: no change
  - 1: bit1 |= r
  - 2: bit2 |= ben
  - 3: bit0 |= ir_11
  - 4: bit3 |= psr_15
  - 5: bit4 |= int_req
  - 6 and 7: reserved, treated as 0
- Bits above ADDR_W-1 are dropped.
- Next-address priority, highest first:
  - ird: zero-extended ir_op (OP_W<=ADDR_W required); stack untouched.
  - ret with sp>0: stack[sp-1]; sp decrements.
  - ret with sp==0: RESET_ADDR; err_unf set.
  - call with sp<STACK_DEPTH: tgt; jm pushed as the return address; sp increments.
  - call with sp==STACK_DEPTH: tgt; no push; err_ovf set.
  - otherwise: jm.
- ird with ret/call simultaneously: ird wins; call and ret ignored, no stack change.
- call and ret together without ird: ret wins.
- upc_next is combinational from current inputs; upc <= upc_next when en=1. Latency from inputs to upc is 1 cycle.
- en=0: upc, sp, stack and flags all hold; upc_next is still driven.
- Memory-wait loop: microcode uses cond=1 with j equal to its own address. The block holds there naturally until r=1; no extra state.
- Sticky flags clear only on rst.
- rst asserted mid-subroutine: stack is discarded and sp=0.

Optional Feature:
- Macro UCODE_SEQ_WDOG_EN.
- Defined:
  - An 8..16-bit counter (width from WDOG_LIMIT) increments each enabled cycle where cond==1, r==0 and upc_next==upc.
  - The counter clears on any other enabled cycle.
  - When the counter reaches WDOG_LIMIT, the next address is forced to TRAP_ADDR (above all other priorities), the counter clears, and output wdog_trip (1 bit, sticky, reset 0) is set.
- Undefined: no counter and no wdog_trip port; a wait holds indefinitely.

Decomposition:
- Shared package ucode_pkg holds:
  - COND encodings: COND_NONE=0, COND_R=1, COND_BEN=2, COND_ADDR=3, COND_PSR=4, COND_INT=5.
  - Default RESET_ADDR (18) and TRAP_ADDR (63) constants.
  - The microinstruction sequencing-field struct {j, cond, ird, call, ret, tgt}.
- One sub-module, ucode_ret_stack: LIFO with push/pop/full/empty/sp. The sequencer owns next-address selection and the error flags.

Test Plan:
- Reset: rst pulse -> upc=18, sp=0, both flags 0; release with j=33, cond=0, en=1 -> upc=33 after one edge.
- Memory wait: j=25, cond=1, r=0 for 5 cycles -> upc stays 25; r=1 -> upc=27.
- Dispatch: ird=1, ir_op=4'b0100, with call=1 and tgt=40 also asserted -> upc=4, sp unchanged.
- Nested calls: 4 calls (tgt=40, j=10/11/12/13) then 4 rets -> upc sequence 40×4 then 13,12,11,10; sp 1..4..0. A 5th call at sp=4 -> err_ovf=1, upc=40, sp=4.
- Underflow and stall: ret at sp=0 -> upc=18, err_unf=1. en=0 with varied inputs -> upc/sp/flags frozen.
- With UCODE_SEQ_WDOG_EN and WDOG_LIMIT=8: hold the wait with r=0 -> after 8 wait cycles upc=63, wdog_trip=1; any r=1 before that -> no trip.
